// File: rtl/qam_symbol_mapper.sv
// Two-stage QPSK/16-QAM/64-QAM mapper with valid/ready flow control.
// Define QAM_SYMBOL_MAPPER_GRAY_EN for Gray-coded axes (binary otherwise).
module qam_symbol_mapper #(
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [5:0]       in_bits,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] symbol_I,
    output logic [OUT_W-1:0] symbol_Q,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sym_cnt,
    output logic             mode_err
);

    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [2:0]       s1_i_q, s1_i_d;
    logic [2:0]       s1_qb_q, s1_qb_d;
    logic             s1_last_q, s1_last_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] sym_i_q, sym_i_d;
    logic [OUT_W-1:0] sym_q_q, sym_q_d;
    logic             s2_last_q, s2_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             s2_load;

    // Keep only the k bits of the axis; in Gray builds also convert to a binary index.
    function automatic logic [2:0] axis_idx(input logic [1:0] m, input logic [2:0] g);
        logic [2:0] b;
        case (m)
            2'd0:    b = {2'b00, g[0]};
            2'd1:    b = {1'b0, g[1:0]};
            2'd2:    b = g;
            default: b = 3'b000;
        endcase
`ifdef QAM_SYMBOL_MAPPER_GRAY_EN
        return {b[2], b[2] ^ b[1], b[2] ^ b[1] ^ b[0]};
`else
        return b;
`endif
    endfunction

    // Odd integer level as a 5-bit two's-complement value.
    function automatic logic [4:0] axis_level(input logic [1:0] m, input logic [2:0] idx);
        logic [4:0] lvl;
`ifdef QAM_SYMBOL_MAPPER_GRAY_EN
        case (m)
            2'd0:    lvl = {1'b0, idx, 1'b0} - 5'd1;
            2'd1:    lvl = {1'b0, idx, 1'b0} - 5'd3;
            2'd2:    lvl = {1'b0, idx, 1'b0} - 5'd7;
            default: lvl = 5'd0;
        endcase
`else
        case (m)
            2'd0:    lvl = {{4{idx[0]}}, 1'b1};
            2'd1:    lvl = {{3{idx[1]}}, idx[1:0], 1'b1};
            2'd2:    lvl = {{2{idx[2]}}, idx, 1'b1};
            default: lvl = 5'd0;
        endcase
`endif
        return lvl;
    endfunction

    // Left-align the level so full scale of every mode reaches the output MSB.
    function automatic logic [OUT_W-1:0] axis_scale(input logic [1:0] m, input logic [4:0] lvl);
        logic [OUT_W-1:0] ext;
        logic [OUT_W-1:0] res;
        ext = {{(OUT_W-5){lvl[4]}}, lvl};
        case (m)
            2'd0:    res = ext << (OUT_W - 2);
            2'd1:    res = ext << (OUT_W - 3);
            2'd2:    res = ext << (OUT_W - 4);
            default: res = '0;
        endcase
        return res;
    endfunction

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_i_d     = s1_i_q;
        s1_qb_d    = s1_qb_q;
        s1_last_d  = s1_last_q;
        err_d      = err_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d = mode;
                s1_i_d    = axis_idx(mode, {in_bits[5], in_bits[3], in_bits[1]});
                s1_qb_d   = axis_idx(mode, {in_bits[4], in_bits[2], in_bits[0]});
                s1_last_d = in_last;
                if (mode == 2'd3) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        sym_i_d    = sym_i_q;
        sym_q_d    = sym_q_q;
        s2_last_d  = s2_last_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sym_i_d   = axis_scale(s1_mode_q, axis_level(s1_mode_q, s1_i_q));
                sym_q_d   = axis_scale(s1_mode_q, axis_level(s1_mode_q, s1_qb_q));
                s2_last_d = s1_last_q;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (s2_valid_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 2'd0;
            s1_i_q     <= 3'd0;
            s1_qb_q    <= 3'd0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            sym_i_q    <= '0;
            sym_q_q    <= '0;
            s2_last_q  <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_i_q     <= s1_i_d;
            s1_qb_q    <= s1_qb_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            sym_i_q    <= sym_i_d;
            sym_q_q    <= sym_q_d;
            s2_last_q  <= s2_last_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign symbol_I  = sym_i_q;
    assign symbol_Q  = sym_q_q;
    assign out_last  = s2_last_q;
    assign out_valid = s2_valid_q;
    assign sym_cnt   = cnt_q;
    assign mode_err  = err_q;

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Bench for qam_symbol_mapper: directed and random symbols against an arithmetic
// constellation model plus an in-flight queue with per-symbol age.
module tb_qam_symbol_mapper;
    localparam int OUT_W = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode = 2'd0;
    logic [5:0]       in_bits = 6'd0;
    logic             in_last = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OUT_W-1:0] symbol_I, symbol_Q;
    logic             out_last, out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] sym_cnt;
    logic             mode_err;

    always #5 clk = ~clk;

    qam_symbol_mapper #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_bits(in_bits), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .symbol_I(symbol_I), .symbol_Q(symbol_Q),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .sym_cnt(sym_cnt), .mode_err(mode_err)
    );

    typedef struct {logic [1:0] mode; logic [5:0] bits; logic last;} sym_t;
    typedef struct {logic [OUT_W-1:0] i; logic [OUT_W-1:0] q; logic last; int age;} exp_t;

    sym_t pend[$];
    exp_t mq[$];
    int   cnt_m;
    bit   err_m;
    int   checks = 0;
    int   errors = 0;

    // Axis value straight from the constellation rules: gather k bits MSB first, form the level.
    function automatic logic [OUT_W-1:0] ref_axis(logic [1:0] m, logic [5:0] b, bit q_axis);
        int k, idx, acc, pos, bitv;
        longint lvl;
        k = (m == 2'd3) ? 0 : int'(m) + 1;
        if (k == 0) return '0;
        idx = 0;
        acc = 0;
        for (int j = 0; j < k; j++) begin
            pos  = 2*k - 1 - 2*j - (q_axis ? 1 : 0);
            bitv = int'(b[pos]);
            acc  = acc ^ bitv;
`ifdef QAM_SYMBOL_MAPPER_GRAY_EN
            idx = idx*2 + acc;
`else
            idx = idx*2 + bitv;
`endif
        end
`ifdef QAM_SYMBOL_MAPPER_GRAY_EN
        lvl = 2*longint'(idx) - ((longint'(1) << k) - 1);
`else
        lvl = (idx >= (1 << (k-1))) ? longint'(idx - (1 << k)) : longint'(idx);
        lvl = 2*lvl + 1;
`endif
        return OUT_W'(lvl * (longint'(1) << (OUT_W - k - 1)));
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(logic [1:0] m, logic [5:0] b, logic l);
        sym_t s;
        s.mode = m; s.bits = b; s.last = l;
        pend.push_back(s);
    endtask

    task automatic step(bit ordy);
        bit exp_rdy, exp_ov, in_fire, out_fire;
        exp_t e;
        rst = 1'b0;
        if (pend.size() > 0) begin
            in_valid = 1'b1; mode = pend[0].mode; in_bits = pend[0].bits; in_last = pend[0].last;
        end else begin
            in_valid = 1'b0; mode = 2'($urandom); in_bits = 6'($urandom); in_last = 1'($urandom);
        end
        out_ready = ordy;
        #1;
        exp_ov  = (mq.size() > 0) && (mq[0].age >= 1);
        exp_rdy = (mq.size() < 2) || ordy;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("symbol_I", 64'(symbol_I), 64'(mq[0].i));
            chk("symbol_Q", 64'(symbol_Q), 64'(mq[0].q));
            chk("out_last", 64'(out_last), 64'(mq[0].last));
        end
        chk("sym_cnt", 64'(sym_cnt), 64'(cnt_m % (1 << CNT_W)));
        chk("mode_err", 64'(mode_err), 64'(err_m));
        in_fire  = in_valid && exp_rdy;
        out_fire = exp_ov && ordy;
        @(posedge clk);
        #1;
        foreach (mq[j]) mq[j].age++;
        if (out_fire) begin
            void'(mq.pop_front());
            cnt_m++;
        end
        if (in_fire) begin
            e.i = ref_axis(mode, in_bits, 1'b0);
            e.q = ref_axis(mode, in_bits, 1'b1);
            e.last = in_last;
            e.age = 0;
            mq.push_back(e);
            if (mode == 2'd3) err_m = 1'b1;
            void'(pend.pop_front());
        end
    endtask

    task automatic reset_step(bit keep_valid);
        rst = 1'b1;
        in_valid = keep_valid;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        pend.delete();
        cnt_m = 0;
        err_m = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sym_cnt", 64'(sym_cnt), 64'd0);
        chk("rst_mode_err", 64'(mode_err), 64'd0);
        chk("rst_symbol_I", 64'(symbol_I), 64'd0);
        chk("rst_symbol_Q", 64'(symbol_Q), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((pend.size() > 0 || mq.size() > 0) && n < 400) begin
            step(1'b1);
            n++;
        end
        if (pend.size() > 0 || mq.size() > 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed=%0d expected=0", mq.size() + pend.size());
        end
    endtask

    initial begin
        reset_step(1'b0);

        // 16-QAM corners back to back
        push(2'd1, 6'b000000, 1'b0);
        push(2'd1, 6'b001111, 1'b1);
        drain();
        chk("cnt_after_two", 64'(sym_cnt), 64'd2);

        // QPSK and 64-QAM
        push(2'd0, 6'b000010, 1'b0);
        push(2'd2, 6'b101010, 1'b1);
        drain();

        // 16-QAM I-axis sweep 00/01/11/10 with Q bits zero
        push(2'd1, 6'b000000, 1'b0);
        push(2'd1, 6'b000010, 1'b0);
        push(2'd1, 6'b001010, 1'b0);
        push(2'd1, 6'b001000, 1'b1);
        drain();

        // Backpressure: five symbols, downstream stalled four cycles
        reset_step(1'b0);
        for (int j = 0; j < 5; j++)
            push(2'($urandom_range(0, 2)), 6'($urandom), (j == 2 || j == 4));
        repeat (4) step(1'b0);
        drain();
        chk("bp_sym_cnt", 64'(sym_cnt), 64'd5);

        // Reserved mode, then sticky error through normal symbols
        push(2'd3, 6'h3F, 1'b1);
        for (int j = 0; j < 3; j++) push(2'($urandom_range(0, 2)), 6'($urandom), 1'b0);
        drain();
        chk("mode_err_sticky", 64'(mode_err), 64'd1);
        reset_step(1'b0);

        // Counter wrap: 17 transfers with a 4-bit counter
        for (int j = 0; j < 17; j++) push(2'($urandom_range(0, 2)), 6'($urandom), 1'($urandom));
        drain();
        chk("wrap_sym_cnt", 64'(sym_cnt), 64'd1);

        // Reset with both stages full and a symbol offered
        reset_step(1'b0);
        for (int j = 0; j < 4; j++) push(2'd1, 6'($urandom), 1'b0);
        repeat (3) step(1'b0);
        reset_step(1'b1);

        // Random traffic with random downstream stalls
        for (int j = 0; j < 300; j++)
            push(($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                 6'($urandom), 1'($urandom));
        for (int n = 0; n < 2000 && pend.size() > 0; n++)
            step($urandom_range(0, 3) != 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
